// File: rtl/uart_recv_hs_pkg.sv
// Shared definitions for the 2 Mbps UART receive path: bit-timing defaults
// (common with the transmitter), FSM state encoding and a timing helper.
package uart_recv_hs_pkg;

    // Default bit timing: 50 MHz system clock, 2 Mbps line rate.
    localparam int CLK_PER_BIT_DEF = 25;
    localparam int CLK_HALF_DEF    = 12;
    localparam int CNT_W_DEF       = 8;

    // Width of one received character.
    localparam int DATA_W = 8;

    // FSM state encoding, kept as plain constants so legacy code can share it.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Counter value at the middle of the stop bit, measured from start-edge
    // detection: half a bit to mid-start, then eight data bits and the stop bit.
    function automatic int stop_point(input int clk_half, input int clk_per_bit);
        return clk_half + 9 * clk_per_bit;
    endfunction

endpackage

// File: rtl/uart_recv_hs_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level. The reset value is a
// parameter so idle-high lines can come out of reset at their idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // values, so this really is two stages and not one.
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_recv_hs.sv
// UART receiver, 8N1, LSB first. Bytes are offered to the host through a
// 4-phase req/ack handshake; framing errors and overruns are reported as
// single-cycle pulses and the offending byte is dropped.
module uart_recv_hs
    import uart_recv_hs_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
    parameter int CLK_HALF    = CLK_HALF_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              uart_rxd,
    output logic              uart_recv_req,
    input  logic              uart_recv_ack,
    output logic [DATA_W-1:0] uart_data_out,
    output logic              uart_frame_err,
    output logic              uart_overrun
);

    // Sample points as counter values. CNT_W must hold STOP_PT.
    localparam logic [CNT_W-1:0] HALF_PT  = CNT_W'(CLK_HALF);
    localparam logic [CNT_W-1:0] BIT_STEP = CNT_W'(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] STOP_PT  = CNT_W'(stop_point(CLK_HALF, CLK_PER_BIT));

    // Input conditioning.
    logic rx_s;
    logic rx_d_q;
    logic start_edge;

    // Handshake input register.
    logic ack_q;

    // FSM and datapath registers.
    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [CNT_W-1:0]  sample_pt_q, sample_pt_d;
    logic [2:0]        bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic              req_q,       req_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q,   overrun_d;
    logic              busy;

    // The line idles high, so the synchronizer resets to 1 and a low line at
    // reset release cannot look like a start edge.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rxd (
        .clk (sys_clk),
        .rst (sys_rst),
        .d_i (uart_rxd),
        .q_o (rx_s)
    );

    // Edge history of the synchronized line and registered consumer ack.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_d_q <= 1'b1;
            ack_q  <= 1'b0;
        end else begin
            rx_d_q <= rx_s;
            ack_q  <= uart_recv_ack;
        end
    end

    assign start_edge = rx_d_q & ~rx_s;

    // The holding register stays busy until the consumer has dropped ack too.
    assign busy = req_q | ack_q;

    // Next-state logic: frame FSM, bit sampling and the handshake.
    always_comb begin
        // NOTE: every signal gets a default before the case, so paths that do
        // not assign it hold the register value instead of inferring a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        sample_pt_d = sample_pt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        req_d       = req_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consumer has taken the byte: drop req. Ack while req=0 does nothing.
        if (req_q && ack_q) begin
            req_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_PT) begin
                    if (rx_s) begin
                        // Line back high at mid-start: a glitch, not a frame.
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_DATA;
                        sample_pt_d = HALF_PT + BIT_STEP;
                        bit_cnt_d   = '0;
                    end
                end
            end

            ST_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == sample_pt_q) begin
                    // LSB arrives first, so shift in from the top.
                    shift_d     = {rx_s, shift_q[DATA_W-1:1]};
                    sample_pt_d = sample_pt_q + BIT_STEP;
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == STOP_PT) begin
                    // Leave at mid-stop so a start edge half a bit later is seen.
                    state_d = ST_IDLE;
                    if (!rx_s) begin
                        // Framing error wins over a coinciding overrun.
                        frame_err_d = 1'b1;
                    end else if (busy) begin
                        overrun_d = 1'b1;
                    end else begin
                        data_d = shift_q;
                        req_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame and clears the held byte.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sample_pt_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            req_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sample_pt_q <= sample_pt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            req_q       <= req_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign uart_recv_req  = req_q;
    assign uart_data_out  = data_q;
    assign uart_frame_err = frame_err_q;
    assign uart_overrun   = overrun_q;

endmodule
